fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Fetch-side partner of the multi-cycle PC register. Presents the current PC to instruction memory through a req/ack handshake and latches the returned word into the instruction register. Holds the instruction valid for the main controller, then issues the one-cycle PCWr pulse that loads NPC into the PC. Sits between PC, instruction memory and the multi-cycle main controller.

Parameters:
TIMEOUT_CYCLES, 16, max cycles REQ may wait for imem_ack (used only with optional feature; min 2)
IR_RESET, 32'h0000_0000, reset/flush value of ir

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
pc  in  32  current PC from PC register
imem_ack  in  1  memory has returned imem_rdata this cycle
imem_rdata  in  32  instruction word, valid when imem_ack=1
exe_done  in  1  main controller finished current instruction; NPC valid
imem_req  out  1  fetch request
imem_addr  out  32  fetch address
ir  out  32  latched instruction
ir_valid  out  1  ir holds an instruction under execution
PCWr  out  1  PC write enable, one-cycle pulse
fetch_cnt  out  32  instructions accepted since reset
misalign  out  1  sticky: pc[1:0]!=0 at fetch
timeout  out  1  sticky: ack not received in time (optional feature)

Behaviour:
- One clock, clk; rst asynchronous active-high. All outputs registered or pure decode of registered state.
- Reset values: state S_INIT, imem_req 0, imem_addr 0, ir IR_RESET, ir_valid 0, PCWr 0, fetch_cnt 0, misalign 0, timeout 0.
- Release from reset mid-operation: always restart at S_INIT. Any outstanding memory access is abandoned. A late imem_ack is ignored.
- S_INIT: exactly one cycle, covering the PC's post-reset load of 0. Then go to S_REQ.
- S_REQ: imem_req=1, imem_addr=pc, stable until ack.
  - If pc[1:0]!=0 on entry cycle: set misalign, go to S_HALT. No request is issued that cycle (imem_req=0).
  - If imem_ack=1 (same cycle allowed, zero-wait memory): ir<=imem_rdata, fetch_cnt<=fetch_cnt+1 (wraps 2^32-1 -> 0), go to S_EXEC.
  - Otherwise remain in S_REQ.
- S_EXEC: ir_valid=1, imem_req=0. On exe_done=1: go to S_UPDATE. ir keeps its value.
- S_UPDATE: PCWr=1, ir_valid=0, exactly one cycle. Then go to S_REQ. The PC updates on this edge, so S_REQ sees the new pc.
- Latency:
  - exe_done at cycle n -> PCWr high in n+1 -> imem_req with new pc in n+2.
  - Zero-wait fetch: ack in cycle k -> ir_valid high in k+1.
- S_HALT: absorbing until rst. All strobes 0; ir, fetch_cnt and sticky flags held.
- Ignored inputs:
  - exe_done outside S_EXEC.
  - imem_ack outside S_REQ, with no ir change.
  - exe_done held high several cycles gives exactly one PCWr per instruction.
- PCWr is never asserted outside S_UPDATE. imem_req and PCWr are never high together.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: a wait counter clears on S_REQ entry and increments each S_REQ cycle without ack. When it reaches TIMEOUT_CYCLES with no ack, set timeout and go to S_HALT (imem_req drops next cycle). An ack in the same cycle the limit is reached wins: the fetch is accepted.
- Undefined: no counter; S_REQ waits indefinitely; timeout tied 0.

Decomposition:
- Shared package/header: state encodings S_INIT=3'd0, S_REQ=3'd1, S_EXEC=3'd2, S_UPDATE=3'd3, S_HALT=3'd4; width constants for instruction and address (32). These join the existing control-encoding definitions header.
- The single natural sub-module is fetch_timer: the wait counter with clear/enable/expired, instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset then pc=0, zero-wait memory returning 32'h2008_0005 -> imem_req in cycle 2 after reset release, ir=32'h2008_0005 and ir_valid=1 next cycle, fetch_cnt=1.
- exe_done pulse in S_EXEC with pc changing 0->4 -> PCWr high exactly one cycle, next imem_addr=4; exe_done held 3 cycles -> still one PCWr.
- Ack delayed 5 cycles -> imem_req and imem_addr stable all 5 cycles, no PCWr, ir unchanged until ack.
- pc=32'h0000_0006 at S_REQ -> misalign=1, S_HALT, no imem_req; rst required to recover.
- Async rst asserted mid-S_REQ between clock edges -> outputs go to reset values immediately; stray ack after release ignored.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> timeout=1 after 16 S_REQ cycles. Ack on cycle 16 -> accepted, timeout stays 0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
// Shared definitions for the fetch sequencer: FSM state encoding and the
// instruction/address widths used between PC, instruction memory and the
// main controller.
package fetch_sequencer_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_REQ    = 3'd1,
        S_EXEC   = 3'd2,
        S_UPDATE = 3'd3,
        S_HALT   = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_timer.sv
// fetch_timer
// Fetch wait timer. Down-counter loaded with TIMEOUT_CYCLES-1 while clear is
// high; counts down on each enabled cycle. expired flags the enabled cycle
// that is the TIMEOUT_CYCLES-th since the last clear.
// Ports:
//   clk, rst  clock, async active-high reset
//   clear     reload the counter (held while not waiting)
//   enable    a waiting cycle is in progress
//   expired   this enabled cycle is the last one allowed
module fetch_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            remaining <= LOAD;
        else if (clear)
            remaining <= LOAD;
        else if (enable && (remaining != '0))
            remaining <= remaining - 1'b1;
    end

    assign expired = enable && (remaining == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Fetch-side sequencer: requests the instruction at pc, latches it into ir,
// holds it valid for the main controller, then pulses PCWr so the PC loads
// NPC. A misaligned pc (or, with FETCH_TIMEOUT_EN, a fetch that waits too
// long) parks the sequencer in S_HALT until reset.
// Optional feature macro: FETCH_TIMEOUT_EN (adds the fetch_timer wait limit).
// Ports:
//   clk, rst     clock, async active-high reset
//   pc           current PC
//   imem_ack     instruction memory returns imem_rdata this cycle
//   imem_rdata   instruction word
//   exe_done     main controller finished the instruction
//   imem_req     fetch request
//   imem_addr    fetch address (0 when no request)
//   ir           latched instruction
//   ir_valid     ir is under execution
//   PCWr         one-cycle PC write enable
//   fetch_cnt    instructions accepted since reset
//   misalign     sticky misaligned-fetch flag
//   timeout      sticky fetch-timeout flag (0 without FETCH_TIMEOUT_EN)
//
// state    | meaning
// S_INIT   | one cycle after reset while the PC loads 0
// S_REQ    | request at pc, wait for imem_ack
// S_EXEC   | ir valid, wait for exe_done
// S_UPDATE | PCWr pulse, PC loads NPC
// S_HALT   | fault, absorbing until reset
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                 TIMEOUT_CYCLES = 16,
    parameter logic [INSTR_W-1:0] IR_RESET       = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               exe_done,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic               PCWr,
    output logic [31:0]        fetch_cnt,
    output logic               misalign,
    output logic               timeout
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    fetch_state_t state, next_state;
    logic         pc_misaligned;
    logic         fetch_accept;
    logic         wait_expired;

    assign pc_misaligned = (pc[1:0] != 2'b00);
    // Misalignment takes priority: no request goes out, so an ack is ignored.
    assign fetch_accept  = (state == S_REQ) && !pc_misaligned && imem_ack;

`ifdef FETCH_TIMEOUT_EN
    fetch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fetch_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != S_REQ),
        .enable  (state == S_REQ),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout <= 1'b0;
        else if ((state == S_REQ) && !pc_misaligned && !imem_ack && wait_expired)
            timeout <= 1'b1;
    end
`else
    assign wait_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_INIT;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_INIT:   next_state = S_REQ;
            S_REQ: begin
                if (pc_misaligned)
                    next_state = S_HALT;
                else if (imem_ack)
                    next_state = S_EXEC;
                else if (wait_expired)
                    next_state = S_HALT;
            end
            S_EXEC:   if (exe_done) next_state = S_UPDATE;
            S_UPDATE: next_state = S_REQ;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_INIT;
        endcase
    end

    always_comb begin
        imem_req  = (state == S_REQ) && !pc_misaligned;
        imem_addr = imem_req ? pc : '0;
        ir_valid  = (state == S_EXEC);
        PCWr      = (state == S_UPDATE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir        <= IR_RESET;
            fetch_cnt <= '0;
        end else if (fetch_accept) begin
            ir        <= imem_rdata;
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign <= 1'b0;
        else if ((state == S_REQ) && pc_misaligned)
            misalign <= 1'b1;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam int          TO  = 16;
    localparam logic [31:0] IRR = 32'hCAFE_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        exe_done = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] ir;
    logic        ir_valid;
    logic        PCWr;
    logic [31:0] fetch_cnt;
    logic        misalign;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    fetch_sequencer #(.TIMEOUT_CYCLES(TO), .IR_RESET(IRR)) dut (
        .clk(clk), .rst(rst), .pc(pc), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .exe_done(exe_done), .imem_req(imem_req),
        .imem_addr(imem_addr), .ir(ir), .ir_valid(ir_valid), .PCWr(PCWr),
        .fetch_cnt(fetch_cnt), .misalign(misalign), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;  logic ack; logic [31:0] rdata; logic exe;
        logic req; logic [31:0] addr; logic [31:0] ir; logic irv;
        logic pcwr; logic [31:0] cnt; logic mis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [31:0] p, logic a, logic [31:0] d, logic e,
                                logic rq, logic [31:0] ad, logic [31:0] i, logic v,
                                logic w, logic [31:0] c, logic m);
        vec_t t;
        t.pc = p; t.ack = a; t.rdata = d; t.exe = e; t.req = rq; t.addr = ad;
        t.ir = i; t.irv = v; t.pcwr = w; t.cnt = c; t.mis = m;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after an edge, inside the S_INIT cycle.
    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; exe_done = 1'b0; imem_rdata = '0; pc = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Reference model: protocol phase flags, not the RTL state encoding.
    logic        m_init, m_exec, m_pcwr, m_halt, m_mis, m_to;
    logic [31:0] m_ir, m_cnt, pc_r;
    int          m_wait;

    task automatic model_reset();
        m_init = 1; m_exec = 0; m_pcwr = 0; m_halt = 0; m_mis = 0; m_to = 0;
        m_ir = IRR; m_cnt = 0; m_wait = 0; pc_r = 0;
    endtask

    initial begin
        logic [31:0] R1, R2, R3, BAD;
        logic        exp_req;
        logic        fetching;
        int          halt_cycles;
        R1 = 32'h2008_0005; R2 = 32'h1111_1111; R3 = 32'h3333_3333; BAD = 32'hDEAD_BEEF;

        // ---- table-driven directed sequence ----
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, IRR, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, R1,  0, 1, 0, IRR, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, BAD, 0, 0, 0, R1,  1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,   1, 0, 0, R1,  1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,   1, 0, 0, R1,  0, 1, 1, 0));
        tbl.push_back(mk(4, 0, 0,   1, 1, 4, R1,  0, 0, 1, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(4, 0, BAD, 0, 1, 4, R1, 0, 0, 1, 0));
        tbl.push_back(mk(4, 1, R2,  0, 1, 4, R1,  0, 0, 1, 0));
        tbl.push_back(mk(4, 0, 0,   0, 0, 0, R2,  1, 0, 2, 0));
        tbl.push_back(mk(4, 0, 0,   1, 0, 0, R2,  1, 0, 2, 0));
        tbl.push_back(mk(4, 0, 0,   0, 0, 0, R2,  0, 1, 2, 0));
        tbl.push_back(mk(8, 1, R3,  0, 1, 8, R2,  0, 0, 2, 0));
        tbl.push_back(mk(8, 0, 0,   1, 0, 0, R3,  1, 0, 3, 0));
        tbl.push_back(mk(8, 0, 0,   0, 0, 0, R3,  0, 1, 3, 0));
        tbl.push_back(mk(6, 1, BAD, 0, 0, 0, R3,  0, 0, 3, 0));
        tbl.push_back(mk(6, 1, BAD, 1, 0, 0, R3,  0, 0, 3, 1));
        tbl.push_back(mk(8, 1, BAD, 1, 0, 0, R3,  0, 0, 3, 1));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            pc = tbl[i].pc; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
            exe_done = tbl[i].exe;
            #4;
            chk($sformatf("tbl%0d imem_req", i),  {31'd0, imem_req},  {31'd0, tbl[i].req});
            chk($sformatf("tbl%0d imem_addr", i), imem_addr,          tbl[i].addr);
            chk($sformatf("tbl%0d ir", i),        ir,                 tbl[i].ir);
            chk($sformatf("tbl%0d ir_valid", i),  {31'd0, ir_valid},  {31'd0, tbl[i].irv});
            chk($sformatf("tbl%0d PCWr", i),      {31'd0, PCWr},      {31'd0, tbl[i].pcwr});
            chk($sformatf("tbl%0d fetch_cnt", i), fetch_cnt,          tbl[i].cnt);
            chk($sformatf("tbl%0d misalign", i),  {31'd0, misalign},  {31'd0, tbl[i].mis});
            chk($sformatf("tbl%0d timeout", i),   {31'd0, timeout},   32'd0);
            tick();
        end

        // ---- async reset mid-S_REQ, stray ack after release ----
        do_reset();
        pc = 0; imem_ack = 0; tick();                       // S_INIT
        imem_ack = 1; imem_rdata = R1; tick();              // fetch
        imem_ack = 0; exe_done = 1; tick();                 // exec
        exe_done = 0; tick();                               // update
        pc = 4; #4;
        chk("arst pre req", {31'd0, imem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst req",       {31'd0, imem_req}, 32'd0);
        chk("arst addr",      imem_addr, 32'd0);
        chk("arst ir",        ir, IRR);
        chk("arst fetch_cnt", fetch_cnt, 32'd0);
        chk("arst ir_valid",  {31'd0, ir_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        imem_ack = 1; imem_rdata = BAD; #4;
        chk("post-arst init req", {31'd0, imem_req}, 32'd0);
        tick();
        imem_ack = 0; #4;
        chk("stray ack ir",       ir, IRR);
        chk("stray ack cnt",      fetch_cnt, 32'd0);
        chk("stray ack ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("post-arst req",      {31'd0, imem_req}, 32'd1);
        tick();

`ifdef FETCH_TIMEOUT_EN
        // ---- timeout: no ack for TO cycles ----
        do_reset();
        pc = 32'h40; tick();
        for (int i = 1; i <= TO; i++) begin
            #4;
            chk($sformatf("to wait%0d req", i), {31'd0, imem_req}, 32'd1);
            chk($sformatf("to wait%0d flag", i), {31'd0, timeout}, 32'd0);
            tick();
        end
        #4;
        chk("to expired req",  {31'd0, imem_req}, 32'd0);
        chk("to expired flag", {31'd0, timeout},  32'd1);
        tick();
        // ---- ack on the limit cycle wins ----
        do_reset();
        pc = 32'h40; tick();
        for (int i = 1; i <= TO; i++) begin
            imem_ack = (i == TO); imem_rdata = R2;
            tick();
        end
        imem_ack = 0; #4;
        chk("to ack-wins ir_valid", {31'd0, ir_valid}, 32'd1);
        chk("to ack-wins ir",       ir, R2);
        chk("to ack-wins flag",     {31'd0, timeout}, 32'd0);
        tick();
`endif

        // ---- randomized run against the reference model ----
        do_reset();
        model_reset();
        halt_cycles = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            pc = pc_r;
            imem_ack   = ($urandom_range(0, 3) == 0);
            imem_rdata = $urandom;
            exe_done   = ($urandom_range(0, 2) == 0);
            fetching   = !m_init && !m_exec && !m_pcwr && !m_halt;
            exp_req    = fetching && (pc_r[1:0] == 2'b00);
            #4;
            chk("rnd imem_req",  {31'd0, imem_req}, {31'd0, exp_req});
            chk("rnd imem_addr", imem_addr, exp_req ? pc_r : 32'd0);
            chk("rnd ir",        ir, m_ir);
            chk("rnd ir_valid",  {31'd0, ir_valid}, {31'd0, m_exec});
            chk("rnd PCWr",      {31'd0, PCWr}, {31'd0, m_pcwr});
            chk("rnd fetch_cnt", fetch_cnt, m_cnt);
            chk("rnd misalign",  {31'd0, misalign}, {31'd0, m_mis});
            chk("rnd timeout",   {31'd0, timeout}, {31'd0, m_to});

            if (m_init) begin
                m_init = 0; m_wait = 0;
            end else if (m_pcwr) begin
                m_pcwr = 0; m_wait = 0;
                pc_r = ($urandom_range(0, 40) == 0) ? pc_r + 32'd2 : pc_r + 32'd4;
            end else if (m_exec) begin
                if (exe_done) begin m_exec = 0; m_pcwr = 1; end
            end else if (!m_halt) begin
                if (pc_r[1:0] != 2'b00) begin
                    m_halt = 1; m_mis = 1;
                end else if (imem_ack) begin
                    m_ir = imem_rdata; m_cnt = m_cnt + 1; m_exec = 1;
                end else begin
                    m_wait++;
`ifdef FETCH_TIMEOUT_EN
                    if (m_wait == TO) begin m_halt = 1; m_to = 1; end
`endif
                end
            end
            tick();

            if (m_halt) halt_cycles++;
            if (halt_cycles > 3) begin
                halt_cycles = 0;
                do_reset();
                model_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
